address_sequencer: RTL and testbench
====================================

# address_sequencer

Parametrised address generator for memory sweeps. It is the successor to the enable-gated address counter. On a start pulse it latches a base/limit/step/direction configuration and emits one address per accepted beat over a valid/ready handshake. It runs either one pass or wraps continuously. It sits between the sweep controller and the RAM read/write port.

## Interface
- ADDR_W, 10, address width
- STEP_W, 4, step width; step 0 is treated as 1
- PASS_W, 8, width of the completed-pass counter
- CLEAR_ON_IDLE, 1, when 1 addr reads 0 in IDLE (legacy counter behaviour); when 0 addr holds its last value
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; latches cfg_* and begins a sweep
- abort  in  1  returns to IDLE without done
- cfg_base  in  ADDR_W  lowest address, inclusive
- cfg_limit  in  ADDR_W  highest address, inclusive
- cfg_step  in  STEP_W  address increment
- cfg_down  in  1  0 = sweep base→limit, 1 = sweep limit→base
- cfg_wrap  in  1  0 = one pass, 1 = continuous passes
- addr_ready  in  1  consumer accepts the current address
- addr  out  ADDR_W  current address
- addr_valid  out  1  addr is valid
- addr_last  out  1  addr is the final beat of the current pass
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse at end of a one-shot sweep
- cfg_err  out  1  one-cycle pulse when start is rejected because base > limit
- pass_count  out  PASS_W  number of completed passes, saturating

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN on start, only when abort=0 and cfg_base ≤ cfg_limit. The configuration is latched into registers. addr loads cfg_base (up) or cfg_limit (down). pass_count clears.
- IDLE with start and base > limit: cfg_err pulses for 1 cycle. The block stays in IDLE and pass_count is unchanged.
- A beat is accepted when addr_valid & addr_ready.
- Next-address calculation uses ADDR_W+1 bits:
  - up: next = addr + step; last when next > limit or carry-out is set.
  - down: next = addr − step; last when next < base or borrow is set.
- An accepted non-last beat moves addr to next.
- An accepted last beat increments pass_count (saturating at all-ones).
  - wrap=1: addr reloads the start address and the block stays in RUN.
  - wrap=0: RUN → DONE.
- DONE lasts 1 cycle. done=1 and addr_valid=0 during it, then the block goes to IDLE.
- abort in RUN or DONE goes to IDLE next cycle. No done pulse; pass_count is retained.
- abort has priority over the handshake and over start.
- start while in RUN or DONE is ignored. The latched configuration is never changed mid-sweep.
- A cfg_* change during RUN has no effect.

## Timing
- Reset state: IDLE. addr, addr_valid, addr_last, busy, done, cfg_err and pass_count are all 0.
- start accepted in cycle N gives addr_valid=1 with the first address in cycle N+1.
- Throughput is 1 address per cycle while addr_ready=1.
- Backpressure: with addr_valid=1 and addr_ready=0, addr and addr_last hold stable. addr_valid never drops in RUN except on abort.
- addr_last is registered alongside addr. There is no combinational path from addr_ready to any output.
- Last beat accepted in cycle M (wrap=0): done=1 and busy=0 in cycle M+1, IDLE in M+2.
- Reset asserted mid-sweep clears all outputs immediately, without waiting for a clock edge.

## Structure
- Package addr_seq_pkg holds:
  - the state enum `addr_seq_state_t` (IDLE/RUN/DONE);
  - a packed struct `addr_seq_cfg_t` (base, limit, step, down, wrap), parametrised via package localparams that match the defaults.
- Sub-module addr_step_calc: purely combinational. Inputs are addr, step and the latched cfg. Outputs are next address, last flag and start address. This isolates the width/overflow logic for unit testing.
- The top level contains the FSM, config register, address register, pass counter and pulse outputs.

## Test plan
- Up, one-shot: base=4, limit=10, step=3, ready=1 → addrs 4, 7, 10 with addr_last on 10. done pulses the cycle after 10 is accepted. pass_count=1.
- Inexact limit: base=0, limit=9, step=4 → 0, 4, 8 with addr_last on 8. step=0 with base=0, limit=2 → 0, 1, 2.
- Down with wrap: base=2, limit=5, step=1 → 5, 4, 3, 2, 5, 4… pass_count increments after each 2. abort at addr 4 → busy=0 next cycle, no done, pass_count retained.
- Backpressure: ready low for 3 cycles at addr 7 → addr=7 and addr_valid=1 stable. Resuming gives 10.
- Overflow: base=1020, limit=1023, step=15, up → single beat 1020 with addr_last=1. Start while busy is ignored.
- Errors and reset: base=8, limit=3, start → cfg_err one pulse, busy=0. Async reset mid-RUN → all outputs 0 before the next edge. With CLEAR_ON_IDLE=1, addr=0 in IDLE.

Source files
------------

// File: rtl/address_sequencer_pkg.sv
// addr_seq_pkg: shared types for the address sequencer.
// Provides the state enum, the latched sweep configuration struct and the
// default widths that the struct is built from.
package addr_seq_pkg;
    localparam int AS_ADDR_W = 10;
    localparam int AS_STEP_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} addr_seq_state_t;

    typedef struct packed {
        logic [AS_ADDR_W-1:0] base;
        logic [AS_ADDR_W-1:0] limit;
        logic [AS_STEP_W-1:0] step;
        logic                 down;
        logic                 wrap;
    } addr_seq_cfg_t;
endpackage

// File: rtl/address_sequencer_if.sv
// address_sequencer_if: address stream from the sequencer to the RAM port.
// Ports: addr, addr_valid, addr_last driven by the master; addr_ready by the slave.
interface address_sequencer_if #(parameter int ADDR_W = 10);
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_last;
    logic              addr_ready;

    modport master(output addr, output addr_valid, output addr_last, input addr_ready);
    modport slave(input addr, input addr_valid, input addr_last, output addr_ready);
endinterface

// File: rtl/address_sequencer_step_calc.sv
// addr_step_calc: combinational next-address, last-beat and start-address logic.
// Ports: addr (current address), cfg (latched configuration) in;
//        next_addr, start_addr, last out.
module addr_step_calc
    import addr_seq_pkg::*;
(
    input  logic [AS_ADDR_W-1:0] addr,
    input  addr_seq_cfg_t        cfg,
    output logic [AS_ADDR_W-1:0] next_addr,
    output logic [AS_ADDR_W-1:0] start_addr,
    output logic                 last
);
    logic [AS_STEP_W-1:0] step_eff;
    logic [AS_ADDR_W:0]   step_x;
    logic [AS_ADDR_W:0]   sum;
    logic [AS_ADDR_W:0]   diff;

    // A zero step would never advance, so it behaves as step 1.
    assign step_eff   = (cfg.step == '0) ? AS_STEP_W'(1) : cfg.step;
    assign step_x     = (AS_ADDR_W+1)'(step_eff);
    // The extra top bit catches carry (up) or borrow (down) past the address range.
    assign sum        = {1'b0, addr} + step_x;
    assign diff       = {1'b0, addr} - step_x;
    assign next_addr  = cfg.down ? diff[AS_ADDR_W-1:0] : sum[AS_ADDR_W-1:0];
    assign last       = cfg.down ? (diff[AS_ADDR_W] || diff[AS_ADDR_W-1:0] < cfg.base)
                                 : (sum[AS_ADDR_W] || sum[AS_ADDR_W-1:0] > cfg.limit);
    assign start_addr = cfg.down ? cfg.limit : cfg.base;
endmodule

// File: rtl/address_sequencer.sv
// address_sequencer: configurable base/limit/step address sweep over a valid/ready stream.
// Ports: clk, reset (async, active-high); start/abort control; cfg_* sweep setup
//        latched on start; bus (master) carries addr/addr_valid/addr_last/addr_ready;
//        busy, done, cfg_err status; pass_count of completed passes (saturating).
module address_sequencer
    import addr_seq_pkg::*;
#(
    parameter int ADDR_W        = AS_ADDR_W,
    parameter int STEP_W        = AS_STEP_W,
    parameter int PASS_W        = 8,
    parameter bit CLEAR_ON_IDLE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_limit,
    input  logic [STEP_W-1:0]   cfg_step,
    input  logic                cfg_down,
    input  logic                cfg_wrap,
    address_sequencer_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [PASS_W-1:0]   pass_count
);
    addr_seq_state_t   state_q, state_d;
    addr_seq_cfg_t     cfg_q, cfg_d;
    logic [ADDR_W-1:0] addr_q, addr_d, next_q, next_d, start_d, idle_addr;
    logic              last_q, last_d, calc_last;
    logic              valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              go, fire;

    assign go        = state_q == IDLE && start && !abort && cfg_base <= cfg_limit;
    assign fire      = valid_q && bus.addr_ready;
    assign idle_addr = CLEAR_ON_IDLE ? '0 : addr_q;
    assign cfg_d     = go ? '{base: cfg_base, limit: cfg_limit, step: cfg_step,
                              down: cfg_down, wrap: cfg_wrap} : cfg_q;

    // Evaluated on the address about to be registered, so next/last are
    // ready as flops alongside addr and addr_ready never reaches an output.
    addr_step_calc u_calc (
        .addr       (addr_d),
        .cfg        (cfg_d),
        .next_addr  (next_d),
        .start_addr (start_d),
        .last       (calc_last)
    );

    assign last_d = valid_d && calc_last;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pass_d  = pass_q;
        if (state_q == IDLE) begin
            if (go) begin
                state_d = RUN;
                addr_d  = start_d;
                valid_d = 1'b1;
                pass_d  = '0;
            end else begin
                // Not accepted despite start without abort: base > limit.
                err_d = start && !abort;
            end
        end else if (abort || state_q == DONE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            addr_d  = idle_addr;
        end else if (fire) begin
            if (last_q) begin
                pass_d = &pass_q ? pass_q : pass_q + 1'b1;
                if (cfg_q.wrap) begin
                    addr_d = start_d;
                end else begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                addr_d = next_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            addr_q  <= '0;
            next_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.addr_valid = valid_q;
    assign bus.addr_last  = last_q;
    assign busy           = state_q == RUN;
    assign done           = done_q;
    assign cfg_err        = err_q;
    assign pass_count     = pass_q;
endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer: self-checking bench for address_sequencer.
module tb_address_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [9:0] cfg_base, cfg_limit;
    logic [3:0] cfg_step;
    logic       cfg_down, cfg_wrap;
    logic       busy, done, cfg_err;
    logic [7:0] pass_count;

    int checks = 0;
    int errors = 0;

    typedef struct {int base; int limit; int step; bit down; int beats;} vec_t;
    typedef struct {int a; bit l;} exp_t;
    exp_t q[$];
    vec_t vt[9];

    always #5 clk = ~clk;

    address_sequencer_if #(.ADDR_W(10)) bus ();

    address_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_base   (cfg_base),
        .cfg_limit  (cfg_limit),
        .cfg_step   (cfg_step),
        .cfg_down   (cfg_down),
        .cfg_wrap   (cfg_wrap),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .pass_count (pass_count)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Reference sweep built with unbounded integers, independent of bit widths.
    task automatic model(input int base, input int limit, input int step, input bit down);
        int s = (step == 0) ? 1 : step;
        int a = down ? limit : base;
        int nx;
        bit l;
        forever begin
            nx = down ? a - s : a + s;
            l  = down ? (nx < base) : (nx > limit);
            q.push_back('{a, l});
            if (l) break;
            a = nx;
        end
    endtask

    task automatic check_zero(input string n);
        chk({n, "_addr"}, bus.addr, 0);
        chk({n, "_valid"}, bus.addr_valid, 0);
        chk({n, "_last"}, bus.addr_last, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_done"}, done, 0);
        chk({n, "_err"}, cfg_err, 0);
        chk({n, "_pass"}, pass_count, 0);
    endtask

    // Called at a negedge; returns at the negedge where the first address shows.
    task automatic start_sweep(input int b, input int l, input int s, input bit d, input bit w);
        cfg_base = 10'(b);
        cfg_limit = 10'(l);
        cfg_step = 4'(s);
        cfg_down = d;
        cfg_wrap = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_base = 10'($urandom);
        cfg_limit = 10'($urandom);
        cfg_step = 4'($urandom);
        cfg_down = 1'($urandom);
        cfg_wrap = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int beats = 0;
        bit seen = 0;
        bit exp_done = 0;
        bit rdy;
        exp_t e;
        q.delete();
        model(v.base, v.limit, v.step, v.down);
        start_sweep(v.base, v.limit, v.step, v.down, 1'b0);
        chk("first_valid", bus.addr_valid, 1);
        for (int c = 0; c < 300 && !seen; c++) begin
            if (exp_done) begin
                chk("done_pulse", done, 1);
                chk("done_valid", bus.addr_valid, 0);
                chk("done_busy", busy, 0);
            end
            if (done) begin
                seen = 1;
            end else begin
                rdy = $urandom_range(0, 3) != 0;
                exp_done = 0;
                if (bus.addr_valid && rdy) begin
                    if (q.size() == 0) begin
                        chk("extra_beat", bus.addr, 32'hffff_ffff);
                    end else begin
                        e = q.pop_front();
                        chk("beat_addr", bus.addr, e.a);
                        chk("beat_last", bus.addr_last, e.l);
                        exp_done = e.l;
                    end
                    beats++;
                end
                bus.addr_ready = rdy;
                @(negedge clk);
            end
        end
        bus.addr_ready = 1'b0;
        chk("done_seen", seen, 1);
        chk("beat_count", beats, v.beats);
        chk("queue_empty", q.size(), 0);
        chk("pass_one", pass_count, 1);
        @(negedge clk);
        chk("idle_addr", bus.addr, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    int wseq[6];

    initial begin
        vt[0] = '{4, 10, 3, 0, 3};
        vt[1] = '{0, 9, 4, 0, 3};
        vt[2] = '{0, 2, 0, 0, 3};
        vt[3] = '{1020, 1023, 15, 0, 1};
        vt[4] = '{2, 5, 1, 1, 4};
        vt[5] = '{5, 5, 3, 1, 1};
        vt[6] = '{0, 7, 2, 1, 4};
        vt[7] = '{100, 300, 7, 1, 29};
        vt[8] = '{1000, 1023, 8, 0, 3};
        wseq = '{5, 4, 3, 2, 5, 4};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_base = '0;
        cfg_limit = '0;
        cfg_step = '0;
        cfg_down = 1'b0;
        cfg_wrap = 1'b0;
        bus.addr_ready = 1'b0;
        #3;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_vec(vt[i]);

        // Down sweep with wrap, then abort at the second pass's address 4.
        start_sweep(2, 5, 1, 1'b1, 1'b1);
        bus.addr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("wrap_addr", bus.addr, wseq[i]);
            chk("wrap_last", bus.addr_last, i == 3);
            chk("wrap_pass", pass_count, i >= 4);
            if (i == 5) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        bus.addr_ready = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", bus.addr_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass_count, 1);
        @(negedge clk);
        chk("abort_nodone", done, 0);

        // Backpressure at address 7, then resume to 10.
        start_sweep(4, 10, 3, 1'b0, 1'b0);
        bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.addr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_addr", bus.addr, 7);
            chk("bp_valid", bus.addr_valid, 1);
            chk("bp_last", bus.addr_last, 0);
            @(negedge clk);
        end
        bus.addr_ready = 1'b1;
        chk("bp_hold", bus.addr, 7);
        @(negedge clk);
        chk("bp_resume", bus.addr, 10);
        chk("bp_resume_last", bus.addr_last, 1);
        @(negedge clk);
        bus.addr_ready = 1'b0;
        chk("bp_done", done, 1);
        @(negedge clk);

        // Overflow single beat; a start while busy must not disturb it.
        start_sweep(1020, 1023, 15, 1'b0, 1'b0);
        chk("ovf_addr", bus.addr, 1020);
        chk("ovf_last", bus.addr_last, 1);
        start_sweep(0, 5, 1, 1'b0, 1'b0);
        chk("busy_start_addr", bus.addr, 1020);
        chk("busy_start_last", bus.addr_last, 1);
        chk("busy_start_busy", busy, 1);
        bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.addr_ready = 1'b0;
        chk("ovf_done", done, 1);
        chk("ovf_pass", pass_count, 1);
        @(negedge clk);

        // Rejected configuration.
        start_sweep(8, 3, 1, 1'b0, 1'b0);
        chk("err_pulse", cfg_err, 1);
        chk("err_busy", busy, 0);
        chk("err_valid", bus.addr_valid, 0);
        chk("err_pass", pass_count, 1);
        @(negedge clk);
        chk("err_once", cfg_err, 0);

        // Asynchronous reset mid-sweep.
        start_sweep(0, 100, 1, 1'b0, 1'b0);
        bus.addr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        bus.addr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
